// File: rtl/alu_pkg.sv
// Shared ALU operation/status types plus the arbiter's state encoding and requester limit.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4
   } alu_op_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_status_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_EXEC,
      ARB_RESP
   } alu_arb_state_e;

   localparam int ALU_ARB_MAX_REQ = 8;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping at NUM_REQ.
module rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0]   idx_o,
   output logic               any_o
);

   always_comb begin
      int j;
      j     = 0;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(ptr_i) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = PTR_W'(j);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU; one op in flight, response held until accepted.
// Optional per-requester carry chaining is enabled by defining ALU_ARB_CARRY_EN.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_REQ-1:0]  req_valid,
   output logic [NUM_REQ-1:0]  req_ready,
   input  alu_op_e             req_op [NUM_REQ],
   input  logic [31:0]         req_a [NUM_REQ],
   input  logic [31:0]         req_b [NUM_REQ],
   input  logic [NUM_REQ-1:0]  req_use_carry,
   output logic [NUM_REQ-1:0]  rsp_valid,
   input  logic [NUM_REQ-1:0]  rsp_ready,
   output logic [31:0]         rsp_result,
   output alu_status_t         rsp_status,
   output logic                alu_oe,
   output alu_op_e             alu_operation,
   output logic                alu_carry_in,
   output logic [31:0]         alu_a,
   output logic [31:0]         alu_b,
   input  logic [31:0]         alu_out,
   input  alu_status_t         alu_status
);

   localparam int PTR_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > ALU_ARB_MAX_REQ) begin : g_bad_num_req
      $error("alu_arbiter: NUM_REQ out of range");
   end

   alu_arb_state_e      state_q, state_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]    grant_q;
   alu_op_e             op_q;
   logic [31:0]         a_q, b_q;
   logic [31:0]         rsp_result_q;
   alu_status_t         rsp_status_q;

   logic [NUM_REQ-1:0]  pick_gnt;
   logic [PTR_W-1:0]    pick_idx;
   logic                pick_any;
   logic                accept;
   logic                capture;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_picker (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign capture = (state_q == ARB_EXEC);

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      req_ready = '0;
      rsp_valid = '0;
      accept    = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               req_ready = pick_gnt;
               accept    = 1'b1;
               state_d   = ARB_EXEC;
            end
         end
         ARB_EXEC: state_d = ARB_RESP;
         ARB_RESP: begin
            rsp_valid[grant_q] = 1'b1;
            // Only the owner's rsp_ready releases the response; next search starts past it.
            if (rsp_ready[grant_q]) begin
               state_d  = ARB_IDLE;
               rr_ptr_d = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         op_q         <= ALU_ADD;
         a_q          <= '0;
         b_q          <= '0;
         rsp_result_q <= '0;
         rsp_status_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         if (accept) begin
            grant_q <= pick_idx;
            op_q    <= req_op[pick_idx];
            a_q     <= req_a[pick_idx];
            b_q     <= req_b[pick_idx];
         end
         if (capture) begin
            rsp_result_q <= alu_out;
            rsp_status_q <= alu_status;
         end
      end
   end

`ifdef ALU_ARB_CARRY_EN
   logic               use_carry_q;
   logic [NUM_REQ-1:0] carry_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         use_carry_q <= 1'b0;
         carry_q     <= '0;
      end else begin
         if (accept) use_carry_q <= req_use_carry[pick_idx];
         if (capture) carry_q[grant_q] <= alu_status.c;
      end
   end

   assign alu_carry_in = use_carry_q & carry_q[grant_q];
`else
   logic unused_use_carry;

   assign unused_use_carry = ^req_use_carry;
   assign alu_carry_in     = 1'b0;
`endif

   // Operands hold their last latched value so the ALU inputs stay quiet between ops.
   assign alu_oe        = (state_q == ARB_EXEC);
   assign alu_operation = op_q;
   assign alu_a         = a_q;
   assign alu_b         = b_q;
   assign rsp_result    = rsp_result_q;
   assign rsp_status    = rsp_status_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU behind it.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int NUM_REQ = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] req_ready;
   alu_op_e            req_op [NUM_REQ];
   logic [31:0]        req_a [NUM_REQ];
   logic [31:0]        req_b [NUM_REQ];
   logic [NUM_REQ-1:0] req_use_carry;
   logic [NUM_REQ-1:0] rsp_valid;
   logic [NUM_REQ-1:0] rsp_ready;
   logic [31:0]        rsp_result;
   alu_status_t        rsp_status;
   logic               alu_oe;
   alu_op_e            alu_operation;
   logic               alu_carry_in;
   logic [31:0]        alu_a, alu_b, alu_out;
   alu_status_t        alu_status;
   logic [32:0]        sum33;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_use_carry (req_use_carry),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_result    (rsp_result),
      .rsp_status    (rsp_status),
      .alu_oe        (alu_oe),
      .alu_operation (alu_operation),
      .alu_carry_in  (alu_carry_in),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_out       (alu_out),
      .alu_status    (alu_status)
   );

   // Behavioural ALU: C is carry-out for ADD and borrow for SUB; outputs zero unless enabled.
   always_comb begin
      sum33      = 33'd0;
      alu_out    = '0;
      alu_status = '0;
      case (alu_operation)
         ALU_ADD: sum33 = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_carry_in};
         ALU_SUB: sum33 = {1'b0, alu_a} - {1'b0, alu_b};
         ALU_AND: sum33 = {1'b0, alu_a & alu_b};
         ALU_OR:  sum33 = {1'b0, alu_a | alu_b};
         ALU_XOR: sum33 = {1'b0, alu_a ^ alu_b};
         default: sum33 = 33'd0;
      endcase
      if (alu_oe) begin
         alu_out      = sum33[31:0];
         alu_status.n = sum33[31];
         alu_status.z = (sum33[31:0] == 32'd0);
         alu_status.c = sum33[32];
         if (alu_operation == ALU_ADD)
            alu_status.v = (alu_a[31] == alu_b[31]) && (sum33[31] != alu_a[31]);
         else if (alu_operation == ALU_SUB)
            alu_status.v = (alu_a[31] != alu_b[31]) && (sum33[31] != alu_a[31]);
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input alu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic uc);
      req_valid[i]     = 1'b1;
      req_op[i]        = op;
      req_a[i]         = a;
      req_b[i]         = b;
      req_use_carry[i] = uc;
   endtask

   // Runs one accept/exec/response sequence for requester g, optionally stalling the response.
   task automatic serve(input string tag, input int g, input bit drop, input int hold,
                        input logic [31:0] exp_res, input logic [3:0] exp_st);
      logic [NUM_REQ-1:0] oh;
      oh    = '0;
      oh[g] = 1'b1;
      #1;
      check_eq({tag, "_req_ready"}, req_ready, oh);
      tick();
      if (drop) req_valid[g] = 1'b0;
      #1;
      check_eq({tag, "_exec_oe"}, alu_oe, 1);
      check_eq({tag, "_exec_rsp_valid"}, rsp_valid, 0);
      tick();
      check_eq({tag, "_rsp_valid"}, rsp_valid, oh);
      check_eq({tag, "_result"}, rsp_result, exp_res);
      check_eq({tag, "_status"}, rsp_status, exp_st);
      for (int h = 0; h < hold; h++) begin
         rsp_ready = ~oh;
         tick();
         check_eq({tag, "_hold_rsp_valid"}, rsp_valid, oh);
         check_eq({tag, "_hold_result"}, rsp_result, exp_res);
         check_eq({tag, "_hold_req_ready"}, req_ready, 0);
      end
      rsp_ready = oh;
      tick();
      rsp_ready = '0;
      #1;
      check_eq({tag, "_rsp_done"}, rsp_valid, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req_ready"}, req_ready, 0);
      check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
      check_eq({tag, "_rsp_result"}, rsp_result, 0);
      check_eq({tag, "_rsp_status"}, rsp_status, 0);
      check_eq({tag, "_alu_oe"}, alu_oe, 0);
      check_eq({tag, "_alu_a"}, alu_a, 0);
      check_eq({tag, "_alu_b"}, alu_b, 0);
      check_eq({tag, "_alu_op"}, alu_operation, ALU_ADD);
      check_eq({tag, "_carry_in"}, alu_carry_in, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      req_valid     = '0;
      req_use_carry = '0;
      rsp_ready     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_op[i] = ALU_ADD;
         req_a[i]  = '0;
         req_b[i]  = '0;
      end
      tick();
      tick();
      check_reset_outputs("por");
      rst = 1'b0;

      // Single ADD 1+1
      drive(0, ALU_ADD, 32'd1, 32'd1, 1'b0);
      serve("add", 0, 1'b1, 0, 32'd2, 4'b0000);
      check_eq("idle_oe", alu_oe, 0);
      check_eq("idle_hold_a", alu_a, 32'd1);
      check_eq("idle_hold_op", alu_operation, ALU_ADD);

      // Two simultaneous SUBs from rr_ptr=0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(0, ALU_SUB, 32'd2, 32'd3, 1'b0);
      drive(1, ALU_SUB, 32'd1, 32'd1, 1'b0);
      serve("sub0", 0, 1'b1, 0, 32'hffff_ffff, 4'b1010);
      serve("sub1", 1, 1'b1, 0, 32'h0000_0000, 4'b0100);

      // Both held for six ops: grants must alternate starting at 0, first response stalled
      drive(0, ALU_XOR, 32'hf0f0_f0f0, 32'hffff_0000, 1'b0);
      drive(1, ALU_AND, 32'h8000_0001, 32'h8000_0000, 1'b0);
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0)
            serve($sformatf("alt%0d", k), 0, 1'b0, (k == 0) ? 5 : 0, 32'h0f0f_f0f0, 4'b0000);
         else
            serve($sformatf("alt%0d", k), 1, 1'b0, 0, 32'h8000_0000, 4'b1000);
      end
      req_valid = '0;

      // Reset while an op is in EXEC
      drive(0, ALU_ADD, 32'd5, 32'd6, 1'b0);
      #1;
      check_eq("rstx_req_ready", req_ready, 2'b01);
      tick();
      req_valid = '0;
      rst       = 1'b1;
      tick();
      check_reset_outputs("rstx");
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         check_eq("rstx_no_rsp", rsp_valid, 0);
         check_eq("rstx_no_oe", alu_oe, 0);
      end

      // Carry chaining: req0 produces C=1, then use_carry pulls from the per-requester store
      drive(0, ALU_ADD, 32'hffff_ffff, 32'd2, 1'b0);
      serve("cy_gen", 0, 1'b1, 0, 32'd1, 4'b0010);
      drive(0, ALU_ADD, 32'd0, 32'd0, 1'b1);
`ifdef ALU_ARB_CARRY_EN
      serve("cy_use0", 0, 1'b1, 0, 32'd1, 4'b0000);
`else
      serve("cy_use0", 0, 1'b1, 0, 32'd0, 4'b0100);
`endif
      drive(1, ALU_ADD, 32'd0, 32'd0, 1'b1);
      serve("cy_use1", 1, 1'b1, 0, 32'd0, 4'b0100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
